// File: rtl/pulse_sync_pkg.sv
// Shared definitions for the fast/slow pulse crossing pair: FSM state
// encoding and the default stretch/gap sizing used by both ends.
package pulse_sync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } ps_state_e;

  // Defaults sized for a slow clock up to ~2.5x the fast period.
  localparam int PS_STRETCH_DEF = 6;
  localparam int PS_GAP_DEF     = 6;

  // Timer width able to hold max(stretch, gap) - 1, never narrower than 1 bit.
  function automatic int ps_timer_w(input int stretch, input int gap);
    int mx;
    int w;
    mx = (stretch > gap) ? stretch : gap;
    w  = $clog2(mx);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pulse_stretch_fast2slow.sv
// Fast-domain source end of the fast-to-slow pulse crossing. Converts
// single-cycle events into STRETCH-cycle pulses separated by at least GAP
// low cycles, queueing back-to-back events in a saturating pending counter.
module pulse_stretch_fast2slow
  import pulse_sync_pkg::*;
#(
  parameter int STRETCH = PS_STRETCH_DEF,
  parameter int GAP     = PS_GAP_DEF,
  parameter int CNT_W   = 4
) (
  input  logic             clk_fast,
  input  logic             rst_n,
  input  logic             pulse_in,
  output logic             pulse_out,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             overflow
);

  localparam int                TMR_W     = ps_timer_w(STRETCH, GAP);
  localparam logic [TMR_W-1:0]  LOAD_HIGH = TMR_W'(STRETCH - 1);
  localparam logic [TMR_W-1:0]  LOAD_LOW  = TMR_W'(GAP - 1);
  localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);
  localparam logic [CNT_W-1:0]  PEND_MAX  = '1;
  localparam logic [CNT_W-1:0]  PEND_ONE  = CNT_W'(1);

  ps_state_e        state;
  logic [TMR_W-1:0] timer;
  logic             tmr_zero;
  logic             consume;
  logic             drop;
  logic [CNT_W-1:0] pend_next;

  // Decode the edge that enters HIGH (consume) and the next pending count.
  always_comb begin
    tmr_zero  = (timer == '0);
    consume   = ((state == ST_IDLE) && pulse_in) ||
                ((state == ST_LOW) && tmr_zero && ((pending != '0) || pulse_in));
    drop      = pulse_in && !consume && (pending == PEND_MAX);
    pend_next = pending;
    if (pulse_in && !consume && !drop) begin
      pend_next = pending + PEND_ONE;
    end else if (!pulse_in && consume) begin
      pend_next = pending - PEND_ONE;
    end
  end

  // FSM with shared down-counter; pulse_out is a registered HIGH decode.
  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      timer     <= '0;
      pulse_out <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pulse_in) begin
            state     <= ST_HIGH;
            timer     <= LOAD_HIGH;
            pulse_out <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (tmr_zero) begin
            state     <= ST_LOW;
            timer     <= LOAD_LOW;
            pulse_out <= 1'b0;
          end else begin
            timer <= timer - TMR_ONE;
          end
        end
        ST_LOW: begin
          if (tmr_zero) begin
            if ((pending != '0) || pulse_in) begin
              state     <= ST_HIGH;
              timer     <= LOAD_HIGH;
              pulse_out <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            timer <= timer - TMR_ONE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          timer     <= '0;
          pulse_out <= 1'b0;
        end
      endcase
    end
  end

  // Pending event counter, saturating at MAX with a one-cycle drop strobe.
  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending  <= pend_next;
      overflow <= drop;
    end
  end

  assign busy = (state != ST_IDLE) || (pending != '0);

endmodule

// File: tb/tb_pulse_stretch_fast2slow.sv
// Bench for pulse_stretch_fast2slow: a default-sized instance and a
// STRETCH=GAP=1 instance share stimulus and are compared every cycle
// against a schedule-based model of pulse start edges.
module tb_pulse_stretch_fast2slow;

  localparam int S0   = 6;
  localparam int G0   = 6;
  localparam int S1   = 1;
  localparam int G1   = 1;
  localparam int MAXP = 15;

  logic       clk_fast;
  logic       rst_n;
  logic       pulse_in;
  logic       po0, busy0, ovf0;
  logic [3:0] pend0;
  logic       po1, busy1, ovf1;
  logic [3:0] pend1;

  int n_chk  = 0;
  int n_fail = 0;
  int edge_no = 0;

  // model state: ring of scheduled pulse start edges per instance
  int st [2][32];
  int rd [2];
  int wr [2];
  int last_started [2];
  int last_sched [2];
  int drops [2];
  bit exp_pulse [2];
  bit exp_busy [2];
  bit exp_ovf [2];
  int exp_pend [2];

  int rises0;
  bit prev_po0;

  pulse_stretch_fast2slow #(.STRETCH(S0), .GAP(G0), .CNT_W(4)) u_dut0 (
    .clk_fast (clk_fast),
    .rst_n    (rst_n),
    .pulse_in (pulse_in),
    .pulse_out(po0),
    .busy     (busy0),
    .pending  (pend0),
    .overflow (ovf0)
  );

  pulse_stretch_fast2slow #(.STRETCH(S1), .GAP(G1), .CNT_W(4)) u_dut1 (
    .clk_fast (clk_fast),
    .rst_n    (rst_n),
    .pulse_in (pulse_in),
    .pulse_out(po1),
    .busy     (busy1),
    .pending  (pend1),
    .overflow (ovf1)
  );

  initial clk_fast = 1'b0;
  always #5 clk_fast = ~clk_fast;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, obs, exp_v, edge_no);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      rd[m] = 0;
      wr[m] = 0;
      last_started[m] = -1000;
      last_sched[m]   = -1000;
      exp_pulse[m] = 1'b0;
      exp_busy[m]  = 1'b0;
      exp_ovf[m]   = 1'b0;
      exp_pend[m]  = 0;
    end
  endtask

  // Each accepted event starts a pulse at max(arrival edge, previous start
  // + STRETCH + GAP); it is pending until that start edge.
  task automatic model_step(input int m, input bit p, input int e);
    int  s_len;
    int  g_len;
    int  cand;
    bit  cons;
    s_len = (m == 0) ? S0 : S1;
    g_len = (m == 0) ? G0 : G1;
    while (rd[m] < wr[m] && st[m][rd[m] % 32] < e) begin
      last_started[m] = st[m][rd[m] % 32];
      rd[m]++;
    end
    cons = (rd[m] < wr[m]) && (st[m][rd[m] % 32] == e);
    exp_ovf[m] = 1'b0;
    if (p) begin
      if ((wr[m] - rd[m]) == MAXP && !cons) begin
        exp_ovf[m] = 1'b1;
        drops[m]++;
      end else begin
        cand = last_sched[m] + s_len + g_len;
        if (cand < e) cand = e;
        st[m][wr[m] % 32] = cand;
        wr[m]++;
        last_sched[m] = cand;
      end
    end
    while (rd[m] < wr[m] && st[m][rd[m] % 32] <= e) begin
      last_started[m] = st[m][rd[m] % 32];
      rd[m]++;
    end
    exp_pend[m]  = wr[m] - rd[m];
    exp_pulse[m] = (e >= last_started[m]) && (e <= last_started[m] + s_len - 1);
    exp_busy[m]  = (e <= last_started[m] + s_len + g_len - 1) || (exp_pend[m] != 0);
  endtask

  task automatic compare_all();
    check("d0.pulse_out", 32'(po0),   32'(exp_pulse[0]));
    check("d0.busy",      32'(busy0), 32'(exp_busy[0]));
    check("d0.pending",   32'(pend0), 32'(exp_pend[0]));
    check("d0.overflow",  32'(ovf0),  32'(exp_ovf[0]));
    check("d1.pulse_out", 32'(po1),   32'(exp_pulse[1]));
    check("d1.busy",      32'(busy1), 32'(exp_busy[1]));
    check("d1.pending",   32'(pend1), 32'(exp_pend[1]));
    check("d1.overflow",  32'(ovf1),  32'(exp_ovf[1]));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".d0.pulse_out"}, 32'(po0),   0);
    check({tag, ".d0.busy"},      32'(busy0), 0);
    check({tag, ".d0.pending"},   32'(pend0), 0);
    check({tag, ".d0.overflow"},  32'(ovf0),  0);
    check({tag, ".d1.pulse_out"}, 32'(po1),   0);
    check({tag, ".d1.busy"},      32'(busy1), 0);
    check({tag, ".d1.pending"},   32'(pend1), 0);
    check({tag, ".d1.overflow"},  32'(ovf1),  0);
  endtask

  // Called at a negedge: drive pulse_in, take one rising edge, check.
  task automatic step(input bit p);
    pulse_in = p;
    @(posedge clk_fast);
    edge_no++;
    model_step(0, p, edge_no);
    model_step(1, p, edge_no);
    @(negedge clk_fast);
    compare_all();
    if (po0 && !prev_po0) rises0++;
    prev_po0 = po0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  // Assert reset between edges and verify outputs clear without a clock edge.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs(tag);
    model_reset();
    pulse_in = 1'b0;
    repeat (2) @(negedge clk_fast);
    rst_n = 1'b1;
    prev_po0 = 1'b0;
  endtask

  initial begin
    int drops_before;
    int thresh;
    rst_n    = 1'b0;
    pulse_in = 1'b0;
    prev_po0 = 1'b0;
    rises0   = 0;
    drops[0] = 0;
    drops[1] = 0;
    model_reset();
    repeat (3) @(negedge clk_fast);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // single event
    idle(4);
    step(1'b1);
    idle(30);

    // burst of three
    step(1'b1); step(1'b1); step(1'b1);
    idle(60);

    // event coincides with the final LOW cycle while one is pending
    step(1'b1); step(1'b1); step(1'b1);
    idle(21);
    step(1'b1);
    check("coincide.pending", 32'(pend0), 1);
    check("coincide.pulse_out", 32'(po0), 1);
    idle(60);

    // saturation: 20-cycle burst
    rises0 = 0;
    drops_before = drops[0];
    for (int i = 0; i < 20; i++) step(1'b1);
    idle(300);
    check("sat.pulse_count", 32'(rises0), 32'(20 - (drops[0] - drops_before)));
    check("sat.dropped_some", 32'(drops[0] - drops_before > 0), 1);

    // reset during the third HIGH cycle
    step(1'b1); step(1'b0); step(1'b0);
    async_reset("rst_mid");
    idle(3);
    rises0 = 0;
    step(1'b1);
    idle(20);
    check("post_rst.pulse_count", 32'(rises0), 1);

    // back-to-back pair (exercises the 1/1 instance)
    step(1'b1); step(1'b1);
    idle(30);

    // randomized traffic with varying density and occasional reset
    for (int seg = 0; seg < 20; seg++) begin
      case ($urandom_range(0, 3))
        0: thresh = 5;
        1: thresh = 20;
        2: thresh = 50;
        default: thresh = 90;
      endcase
      for (int i = 0; i < 200; i++) begin
        step($urandom_range(0, 99) < thresh);
        if ($urandom_range(0, 999) == 0) async_reset("rst_rand");
      end
    end
    idle(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
